// File: rtl/payload_egress_framer_if.sv
// ---------------------------------------------------------------------------
// payload_egress_framer_if
//
// Groups every non-clock/reset signal of the payload egress framer:
//   descriptor side : desc_valid, desc_len -> framer ; desc_ready <- framer
//   payload FIFO    : fifo_q, fifo_empty -> framer   ; fifo_re <- framer
//   egress stream   : m_data, m_valid, m_last <- framer ; m_ready -> framer
//   status          : err_len, pkt_count <- framer
//
// Modports:
//   master : the framer itself (drives the egress stream and FIFO pop)
//   slave  : the surroundings (forwarding logic, FIFO and egress MAC)
// ---------------------------------------------------------------------------
interface payload_egress_framer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11,
  parameter int CNT_WIDTH  = 16
);

  logic                  desc_valid;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  desc_ready;

  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_empty;
  logic                  fifo_re;

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  logic                  err_len;
  logic [CNT_WIDTH-1:0]  pkt_count;

  modport master (
    input  desc_valid, desc_len, fifo_q, fifo_empty, m_ready,
    output desc_ready, fifo_re, m_data, m_valid, m_last, err_len, pkt_count
  );

  modport slave (
    output desc_valid, desc_len, fifo_q, fifo_empty, m_ready,
    input  desc_ready, fifo_re, m_data, m_valid, m_last, err_len, pkt_count
  );

endinterface

// File: rtl/payload_egress_framer.sv
// ---------------------------------------------------------------------------
// payload_egress_framer
//
// Pops exactly desc_len bytes from a first-word-fall-through payload FIFO for
// every accepted length descriptor and presents them as a valid/ready byte
// stream with an end-of-packet marker. Descriptors of length 0 or longer than
// MAX_LEN are consumed and flagged with a one-cycle err_len pulse. A wrapping
// counter tracks packets whose last byte has been handed to the sink.
//
// Ports:
//   CLK     : single clock
//   RESET_N : asynchronous active-low reset
//   bus     : payload_egress_framer_if.master (descriptor, FIFO, egress
//             stream and status signals)
// ---------------------------------------------------------------------------
module payload_egress_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11,
  parameter int MAX_LEN    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  payload_egress_framer_if.master bus
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  err_len_q;
  logic [CNT_WIDTH-1:0]  pkt_count_q;

  logic [LEN_WIDTH-1:0]  remaining_d;
  logic [CNT_WIDTH-1:0]  pkt_count_d;
  logic                  slot_free;
  logic                  pop;
  logic                  last_byte;
  logic                  desc_bad;
  logic                  handoff;

  // The output register can take a new byte when it is empty or its current
  // byte is being accepted this cycle; a pop is only issued in that case, so
  // a held byte is never overwritten and the FIFO is never read while empty.
  assign slot_free   = !m_valid_q || bus.m_ready;
  assign pop         = (state_q == PAYLOAD) && !bus.fifo_empty && slot_free;
  assign last_byte   = (remaining_q == LEN_WIDTH'(1));
  assign remaining_d = remaining_q - LEN_WIDTH'(1);

  assign desc_bad    = (bus.desc_len == '0) ||
                       (bus.desc_len > LEN_WIDTH'(MAX_LEN));

  assign handoff     = m_valid_q && bus.m_ready && m_last_q;
  assign pkt_count_d = pkt_count_q + CNT_WIDTH'(1);

  // desc_ready is gated by RESET_N so it drops the moment reset asserts,
  // not only once the state register has been cleared.
  assign bus.desc_ready = (state_q == IDLE) && RESET_N;
  assign bus.fifo_re    = pop;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.err_len    = err_len_q;
  assign bus.pkt_count  = pkt_count_q;

  // Control FSM plus the output register. Descriptor acceptance only happens
  // in IDLE and pops only in PAYLOAD, so remaining_q never sees a load and a
  // decrement on the same edge. The packet returns to IDLE on the edge that
  // pops its last byte, which lets the next descriptor be accepted while that
  // byte still sits in the output register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      err_len_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      err_len_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.desc_valid) begin
            if (desc_bad) begin
              err_len_q <= 1'b1;
            end else begin
              remaining_q <= bus.desc_len;
              state_q     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pop && last_byte) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (pop) begin
        m_data_q    <= bus.fifo_q;
        m_valid_q   <= 1'b1;
        m_last_q    <= last_byte;
        remaining_q <= remaining_d;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      if (handoff) begin
        pkt_count_q <= pkt_count_d;
      end
    end
  end

endmodule

// File: tb/tb_payload_egress_framer.sv
// ---------------------------------------------------------------------------
// tb_payload_egress_framer
//
// Directed bench for payload_egress_framer. A small FWFT FIFO model feeds the
// framer, a posedge monitor records every accepted egress byte, FIFO pops,
// err_len pulses and handshake rule violations, and each packet scenario is a
// record in a vector table with hand-computed expected results. Back-to-back
// descriptors and reset mid-packet are written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_payload_egress_framer;

  logic CLK;
  logic RESET_N;

  payload_egress_framer_if #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (11),
    .CNT_WIDTH (16)
  ) bus ();

  payload_egress_framer #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (11),
    .MAX_LEN   (1024),
    .CNT_WIDTH (16)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    int          preFill;
    int          lateFill;
    int          lateAt;
    int          descLen;
    logic [7:0]  base;
    logic [15:0] readyPat;
    int          expMid;
    int          expBytes;
    int          expErr;
    int          expPkts;
  } vec_t;

  logic [7:0] fifoMem [2048];
  int         wrPtr = 0;
  int         rdPtr = 0;

  logic [8:0] capQ [$];
  int         capCyc [$];
  int         cycleCount = 0;
  int         popCount = 0;
  int         errCount = 0;
  int         protoErr = 0;
  logic       holdPending = 1'b0;
  logic [7:0] heldData = '0;
  logic       heldLast = 1'b0;

  int         vecCount = 0;
  int         missCount = 0;
  int         expPkt = 0;

  vec_t       vecs [8];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // FWFT FIFO model: the head byte is always visible, a pop advances the
  // read pointer on the clock edge. Writes come from the stimulus process.
  assign bus.fifo_q     = fifoMem[rdPtr % 2048];
  assign bus.fifo_empty = (rdPtr == wrPtr);

  // Monitor: samples pre-edge values on every rising edge, records accepted
  // egress bytes with their cycle, counts pops and err_len pulses, and flags
  // pops from an empty FIFO, pops into an occupied stalled slot, and any
  // change of a held byte while the sink is stalling.
  always @(posedge CLK) begin
    cycleCount++;
    if (bus.fifo_re) begin
      rdPtr <= rdPtr + 1;
      popCount++;
    end
    if (bus.m_valid && bus.m_ready) begin
      capQ.push_back({bus.m_last, bus.m_data});
      capCyc.push_back(cycleCount);
    end
    if (bus.err_len) errCount++;
    if (bus.fifo_re && bus.fifo_empty) protoErr++;
    if (bus.fifo_re && bus.m_valid && !bus.m_ready) protoErr++;
    if (!RESET_N) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending && (!bus.m_valid || bus.m_data != heldData || bus.m_last != heldLast))
        protoErr++;
      holdPending = bus.m_valid && !bus.m_ready;
      heldData    = bus.m_data;
      heldLast    = bus.m_last;
    end
  end

  // Safety net so the run always ends even if a wait loop is broken.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushBytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr % 2048] = 8'(base + i);
      wrPtr++;
    end
  endtask

  // Presents a descriptor and holds it until the framer takes it. Called and
  // returns on a falling edge.
  task automatic issueDesc(input logic [10:0] len, output int timedOut);
    int cyc;
    cyc = 0;
    bus.desc_valid = 1'b1;
    bus.desc_len   = len;
    while (!bus.desc_ready && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    timedOut = bus.desc_ready ? 0 : 1;
    @(posedge CLK);
    @(negedge CLK);
    bus.desc_valid = 1'b0;
    bus.desc_len   = 11'h7FF;
  endtask

  // Drives m_ready from a 16-cycle pattern until the framer is idle with an
  // empty output register, optionally topping up the FIFO part-way through.
  task automatic waitDrain(input int lateAt, input int lateCount, input logic [7:0] lateBase,
                           input logic [15:0] pat, input int capStart,
                           output int timedOut, output int midGot);
    int c;
    c = 0;
    midGot = -1;
    timedOut = 1;
    while (c < 3000) begin
      if (lateCount > 0 && c == lateAt) begin
        midGot = capQ.size() - capStart;
        pushBytes(lateBase, lateCount);
      end
      bus.m_ready = pat[c % 16];
      if (c >= 3 && (lateCount == 0 || c > lateAt) && bus.desc_ready && !bus.m_valid) begin
        timedOut = 0;
        break;
      end
      @(negedge CLK);
      c++;
    end
    bus.m_ready = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int capStart, popStart, errStart, protoStart, timedOut, midGot, bad, nGot;
    capStart   = capQ.size();
    popStart   = popCount;
    errStart   = errCount;
    protoStart = protoErr;
    pushBytes(v.base, v.preFill);
    issueDesc(11'(v.descLen), timedOut);
    checkOutput({v.name, " accept"}, timedOut, 0);
    waitDrain(v.lateAt, v.lateFill, 8'(v.base + v.preFill), v.readyPat, capStart, timedOut, midGot);
    checkOutput({v.name, " drain"}, timedOut, 0);
    if (v.lateFill > 0) checkOutput({v.name, " bytes before refill"}, midGot, v.expMid);
    nGot = capQ.size() - capStart;
    checkOutput({v.name, " byte count"}, nGot, v.expBytes);
    bad = 0;
    for (int i = 0; i < v.expBytes && i < nGot; i++) begin
      if (capQ[capStart + i] != {(i == v.expBytes - 1), 8'(v.base + i)}) bad++;
    end
    checkOutput({v.name, " bad data/last bytes"}, bad, 0);
    checkOutput({v.name, " fifo_re pulses"}, popCount - popStart, v.expBytes);
    checkOutput({v.name, " err_len pulses"}, errCount - errStart, v.expErr);
    checkOutput({v.name, " handshake violations"}, protoErr - protoStart, 0);
    expPkt += v.expPkts;
    checkOutput({v.name, " pkt_count"}, int'(bus.pkt_count), expPkt % 65536);
  endtask

  initial begin
    int   to1, to2, to3, mid, capStart, popStart, nGot, bad, cyc;
    logic [3:0] lastExp;
    int   gapExp [3];
    vec_t tail;

    //                name            pre  late at  len   base   readyPat   mid  bytes err pkts
    vecs[0] = '{"len4",           4,    0,   0,    4, 8'h10, 16'hFFFF, 0,    4, 0, 1};
    vecs[1] = '{"ready_toggle",   3,    0,   0,    3, 8'h20, 16'hF6D9, 0,    3, 0, 1};
    vecs[2] = '{"fifo_starve",    2,    3,  10,    5, 8'h30, 16'hFFFF, 2,    5, 0, 1};
    vecs[3] = '{"len_zero",       0,    0,   0,    0, 8'h00, 16'hFFFF, 0,    0, 1, 0};
    vecs[4] = '{"len_1025",       0,    0,   0, 1025, 8'h00, 16'hFFFF, 0,    0, 1, 0};
    vecs[5] = '{"len_2047",       0,    0,   0, 2047, 8'h00, 16'hFFFF, 0,    0, 1, 0};
    vecs[6] = '{"len_one",        1,    0,   0,    1, 8'h7F, 16'hFFFF, 0,    1, 0, 1};
    vecs[7] = '{"len_max",     1024,    0,   0, 1024, 8'h00, 16'hFFFF, 0, 1024, 0, 1};

    RESET_N        = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_len   = '0;
    bus.m_ready    = 1'b1;

    #1;
    checkOutput("reset desc_ready", int'(bus.desc_ready), 0);
    checkOutput("reset m_valid", int'(bus.m_valid), 0);
    checkOutput("reset m_last", int'(bus.m_last), 0);
    checkOutput("reset fifo_re", int'(bus.fifo_re), 0);
    checkOutput("reset err_len", int'(bus.err_len), 0);
    checkOutput("reset pkt_count", int'(bus.pkt_count), 0);

    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("post-reset desc_ready", int'(bus.desc_ready), 1);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Back-to-back descriptors 1,1,2: each new descriptor is taken on the
    // edge after the previous last byte was popped, so accepted bytes land
    // 2, 2 and 1 cycles apart.
    lastExp   = 4'b1011;
    gapExp    = '{2, 2, 1};
    capStart  = capQ.size();
    popStart  = popCount;
    pushBytes(8'h50, 4);
    issueDesc(11'd1, to1);
    issueDesc(11'd1, to2);
    issueDesc(11'd2, to3);
    checkOutput("b2b accept", to1 + to2 + to3, 0);
    waitDrain(0, 0, 8'h00, 16'hFFFF, capStart, to1, mid);
    checkOutput("b2b drain", to1, 0);
    nGot = capQ.size() - capStart;
    checkOutput("b2b byte count", nGot, 4);
    bad = 0;
    for (int i = 0; i < 4 && i < nGot; i++) begin
      if (capQ[capStart + i] != {lastExp[i], 8'(8'h50 + i)}) bad++;
    end
    checkOutput("b2b bad data/last bytes", bad, 0);
    bad = 0;
    for (int i = 0; i < 3 && i + 1 < nGot; i++) begin
      if (capCyc[capStart + i + 1] - capCyc[capStart + i] != gapExp[i]) bad++;
    end
    checkOutput("b2b wrong byte gaps", bad, 0);
    checkOutput("b2b fifo_re pulses", popCount - popStart, 4);
    expPkt += 3;
    checkOutput("b2b pkt_count", int'(bus.pkt_count), expPkt % 65536);

    // Reset after two bytes of a six-byte packet. Three bytes have been
    // popped by then (one sits in the output register and is lost), so the
    // FIFO keeps 0x63..0x65 for the next descriptor.
    capStart = capQ.size();
    pushBytes(8'h60, 6);
    issueDesc(11'd6, to1);
    checkOutput("rst accept", to1, 0);
    cyc = 0;
    while (capQ.size() - capStart < 2 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("rst bytes before reset", capQ.size() - capStart, 2);
    checkOutput("rst m_valid before reset", int'(bus.m_valid), 1);
    RESET_N = 1'b0;
    #1;
    checkOutput("rst m_valid", int'(bus.m_valid), 0);
    checkOutput("rst m_last", int'(bus.m_last), 0);
    checkOutput("rst fifo_re", int'(bus.fifo_re), 0);
    checkOutput("rst pkt_count", int'(bus.pkt_count), 0);
    checkOutput("rst desc_ready", int'(bus.desc_ready), 0);
    expPkt = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("rst release desc_ready", int'(bus.desc_ready), 1);
    checkOutput("rst bytes left in fifo", wrPtr - rdPtr, 3);

    tail = '{"after_reset", 0, 0, 0, 3, 8'h63, 16'hFFFF, 0, 3, 0, 1};
    applyStimulus(tail);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/payload_egress_framer.md
Name: payload_egress_framer

Overview:
- Downstream consumer of the 8-bit x 1024 first-word-fall-through payload FIFO on the switch egress path.
- Takes per-packet length descriptors from the forwarding logic and pops exactly that many bytes from the payload FIFO.
- Presents the bytes as a valid/ready byte stream with an end-of-packet marker to the egress MAC.
- Rejects malformed descriptors and keeps a sent-packet counter.

Parameters:
DATA_WIDTH, 8, payload byte width; matches the FIFO data width.
LEN_WIDTH, 11, descriptor length field width.
MAX_LEN, 1024, largest legal packet length in bytes; equals the FIFO depth.
CNT_WIDTH, 16, width of the sent-packet counter.

Ports:
CLK  in  1  single clock for all logic.
RESET_N  in  1  asynchronous, active-low reset.
desc_valid  in  1  descriptor present.
desc_len  in  LEN_WIDTH  packet length in bytes.
desc_ready  out  1  descriptor accepted this cycle when desc_valid is also high.
fifo_q  in  DATA_WIDTH  head byte of the payload FIFO; valid whenever fifo_empty=0 (FWFT).
fifo_empty  in  1  payload FIFO empty flag.
fifo_re  out  1  pops the head byte; active high.
m_data  out  DATA_WIDTH  egress byte.
m_valid  out  1  egress byte valid.
m_last  out  1  marks the final byte of a packet; qualified by m_valid.
m_ready  in  1  egress sink accepts the byte.
err_len  out  1  one-cycle pulse when a descriptor has length 0 or length > MAX_LEN.
pkt_count  out  CNT_WIDTH  count of packets fully handed off.

Behaviour:
- Reset (async assert, sync release): state=IDLE, remaining=0; m_valid, m_last, m_data, fifo_re, err_len and pkt_count are all 0.
- desc_ready is combinational: 1 in IDLE, 0 otherwise. It is 0 while RESET_N is low.
- States: IDLE and PAYLOAD.
- IDLE, desc_valid=1, desc_len in 1..MAX_LEN: load remaining=desc_len; go to PAYLOAD next cycle.
- IDLE, desc_valid=1, desc_len=0 or desc_len>MAX_LEN: consume the descriptor; err_len=1 the next cycle; stay in IDLE; no FIFO pop.
- Output slot free: slot_free = !m_valid || m_ready.
- Pop condition: fifo_re = (state==PAYLOAD) && !fifo_empty && slot_free. fifo_re is combinational and never asserts while fifo_empty=1.
- On a pop, at the next edge:
  - m_data<=fifo_q, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1.
  - If remaining==1, state<=IDLE.
- No pop but m_ready=1 with m_valid=1: m_valid<=0 and m_last<=0 next edge.
- m_data, m_valid and m_last stay stable while m_valid=1 and m_ready=0.
- Throughput: one byte per clock when the FIFO is non-empty and the sink is ready. Latency from fifo_re to m_valid is 1 cycle.
- Inter-packet gap: minimum 1 IDLE cycle. A new descriptor may be accepted while the previous packet's last byte is still held in the output register.
- FIFO empty mid-packet: pause with no timeout; remaining is held; resume when fifo_empty=0.
- pkt_count increments by 1 on m_valid && m_ready && m_last. It wraps modulo 2^CNT_WIDTH.
- Reset mid-packet: the partial packet is abandoned; bytes left in the FIFO are not flushed by this block; all outputs return to their reset values immediately.
- desc_len is sampled only on acceptance. Changes to desc_len while desc_ready=0 are ignored.

Test Plan:
1. Push bytes 0x10..0x13 into the FIFO; desc_len=4; m_ready held 1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles; m_last=1 only on 0x13; pkt_count=1; exactly 4 fifo_re pulses.
2. desc_len=3 with m_ready toggling 1,0,0,1,1 -> each byte is held stable while m_ready=0; no byte lost or duplicated; fifo_re never asserts while the slot is occupied and m_ready=0.
3. Only 2 of 5 bytes present at start, 3 more pushed 10 cycles later -> 2 bytes out, output idles, remaining holds at 3, then bytes 3..5 follow with m_last on byte 5; fifo_re=0 throughout the empty period.
4. desc_len=0, then desc_len=1025 -> err_len pulses twice, fifo_re stays 0, pkt_count unchanged, desc_ready returns to 1.
5. Back-to-back descriptors of length 1, 1, 2 with the FIFO pre-filled -> output 1,1,2 bytes; m_last on bytes 1, 2 and 4; 1-cycle gaps; pkt_count=3.
6. RESET_N pulsed low after 2 bytes of a 6-byte packet -> m_valid, m_last, fifo_re and pkt_count go to 0 asynchronously; desc_ready=1 after release; the next descriptor is processed normally.
